execute_muldiv: RTL and testbench

- Multi-cycle integer multiply/divide execution unit; sits beside execute_alu after reg-read.
- Accepts one exec packet per cycle via valid/ready. Multiplies run in a fixed-latency pipeline; divides/remainders run on an iterative radix-2 divider.
- Produces one registered writeback per cycle to the physical register file, the forwarding unit and the ROB. Flush discards all in-flight work.

---
 rtl/execute_muldiv_pkg.sv | 35 +++
 rtl/execute_muldiv_serial_divider.sv | 121 ++++++++++++
 rtl/execute_muldiv.sv | 140 ++++++++++++++
 tb/tb_execute_muldiv.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/execute_muldiv_pkg.sv
// Shared types for the multiply/divide execution unit: opcodes, divider
// state encoding and opcode classification helpers.
package execute_muldiv_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_AND    = 4'd2,
      OP_OR     = 4'd3,
      OP_MUL    = 4'd8,
      OP_MULH   = 4'd9,
      OP_MULHSU = 4'd10,
      OP_MULHU  = 4'd11,
      OP_DIV    = 4'd12,
      OP_DIVU   = 4'd13,
      OP_REM    = 4'd14,
      OP_REMU   = 4'd15
   } instr_opcode_t;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_t;

   function automatic logic op_is_mul(instr_opcode_t op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
   endfunction

   function automatic logic op_is_div(instr_opcode_t op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

endpackage

// File: rtl/execute_muldiv_serial_divider.sv
// Iterative radix-2 restoring divider producing quotient and remainder.
// Results are offered via done; a stalled result is parked in DONE.
//
// state | meaning
// IDLE  | waiting; a special-case start is answered in the same cycle
// CALC  | one quotient bit per cycle, cnt counts down to terminal 0
// FIX   | sign correction applied, corrected result offered
// DONE  | result parked while the output slot is taken
module serial_divider
   import execute_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic            stall,
   input  logic            is_signed,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic            idle,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int CW = $clog2(XLEN);

   div_state_t      state, state_nx;
   logic [XLEN-1:0] quo, rem, dvs;
   logic [CW-1:0]   cnt;
   logic            neg_q, neg_r;

   logic            sign_a, sign_b, div_zero, ovf, special, fits;
   logic [XLEN-1:0] abs_a, abs_b, spec_q, spec_r, fix_q, fix_r;
   logic [XLEN:0]   trial;

   assign sign_a   = is_signed & dividend[XLEN-1];
   assign sign_b   = is_signed & divisor[XLEN-1];
   assign abs_a    = sign_a ? -dividend : dividend;
   assign abs_b    = sign_b ? -divisor : divisor;
   assign div_zero = (divisor == '0);
   assign ovf      = is_signed & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (divisor == '1);
   assign special  = div_zero | ovf;
   assign spec_q   = div_zero ? '1 : dividend;
   assign spec_r   = div_zero ? dividend : '0;
   assign trial    = {rem, quo[XLEN-1]} - {1'b0, dvs};
   assign fits     = ~trial[XLEN];
   assign fix_q    = neg_q ? -quo : quo;
   assign fix_r    = neg_r ? -rem : rem;
   assign idle     = (state == DIV_IDLE);

   always_comb begin
      state_nx  = state;
      done      = 1'b0;
      quotient  = quo;
      remainder = rem;
      case (state)
         DIV_IDLE: begin
            if (start && special) begin
               done      = 1'b1;
               quotient  = spec_q;
               remainder = spec_r;
               if (stall) state_nx = DIV_DONE;
            end else if (start) begin
               state_nx = DIV_CALC;
            end
         end
         DIV_CALC: if (cnt == '0) state_nx = DIV_FIX;
         DIV_FIX: begin
            done      = 1'b1;
            quotient  = fix_q;
            remainder = fix_r;
            state_nx  = stall ? DIV_DONE : DIV_IDLE;
         end
         DIV_DONE: begin
            done = 1'b1;
            if (!stall) state_nx = DIV_IDLE;
         end
         default: state_nx = DIV_IDLE;
      endcase
      if (abort) state_nx = DIV_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= DIV_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      case (state)
         DIV_IDLE: begin
            if (start) begin
               if (special) begin
                  quo <= spec_q;
                  rem <= spec_r;
               end else begin
                  quo <= abs_a;
                  rem <= '0;
               end
               dvs   <= abs_b;
               cnt   <= CW'(XLEN-1);
               neg_q <= sign_a ^ sign_b;
               neg_r <= sign_a;
            end
         end
         DIV_CALC: begin
            quo <= {quo[XLEN-2:0], fits};
            rem <= fits ? trial[XLEN-1:0] : {rem[XLEN-2:0], quo[XLEN-1]};
            cnt <= cnt - CW'(1);
         end
         DIV_FIX: begin
            quo <= fix_q;
            rem <= fix_r;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/execute_muldiv.sv
// Multi-cycle multiply/divide execution unit: fixed-latency multiply pipe plus
// iterative divider sharing one registered writeback port (multiply wins).
module execute_muldiv
   import execute_muldiv_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MUL_STAGES  = 3,
   parameter int ROB_ENTRIES = 64,
   parameter int NUM_PREGS   = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  instr_opcode_t                  in_opcode,
   input  logic [XLEN-1:0]                in_src1_val,
   input  logic [XLEN-1:0]                in_src2_val,
   input  logic [$clog2(NUM_PREGS)-1:0]   in_dst_preg,
   input  logic [$clog2(ROB_ENTRIES)-1:0] in_rob_idx,
   input  logic                           flush,
   output logic                           wb_valid,
   output logic [XLEN-1:0]                wb_val,
   output logic [$clog2(NUM_PREGS)-1:0]   wb_dst_preg,
   output logic [$clog2(ROB_ENTRIES)-1:0] wb_rob_idx,
   output logic                           busy
);

   localparam int PW = $clog2(NUM_PREGS);
   localparam int RW = $clog2(ROB_ENTRIES);
   localparam int NS = MUL_STAGES - 1;

   logic              accept, mul_acc, div_acc;
   logic              sa, sb, div_signed;
   logic [2*XLEN-1:0] a_ext, b_ext, prod;
   logic [XLEN-1:0]   mul_res;

   logic [NS-1:0]     mv;
   logic [XLEN-1:0]   mr   [NS];
   logic [PW-1:0]     mp   [NS];
   logic [RW-1:0]     mrob [NS];
   logic              mul_exit;

   logic              div_idle, div_done;
   logic [XLEN-1:0]   div_q, div_r, div_val;
   logic              d_rem, sel_rem;
   logic [PW-1:0]     d_preg, sel_preg;
   logic [RW-1:0]     d_rob, sel_rob;

   assign in_ready = ~rst & div_idle;
   assign accept   = in_valid & in_ready & ~flush;
   assign mul_acc  = accept & op_is_mul(in_opcode);
   assign div_acc  = accept & op_is_div(in_opcode);

   // Sign-extend to the full product width so one unsigned multiply covers all signedness mixes.
   assign sa      = (in_opcode == OP_MULH) | (in_opcode == OP_MULHSU);
   assign sb      = (in_opcode == OP_MULH);
   assign a_ext   = {{XLEN{sa & in_src1_val[XLEN-1]}}, in_src1_val};
   assign b_ext   = {{XLEN{sb & in_src2_val[XLEN-1]}}, in_src2_val};
   assign prod    = a_ext * b_ext;
   assign mul_res = (in_opcode == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         mv <= '0;
      end else begin
         mv[0] <= mul_acc;
         for (int i = 1; i < NS; i++) mv[i] <= mv[i-1];
      end
   end

   always_ff @(posedge clk) begin
      mr[0]   <= mul_res;
      mp[0]   <= in_dst_preg;
      mrob[0] <= in_rob_idx;
      for (int i = 1; i < NS; i++) begin
         mr[i]   <= mr[i-1];
         mp[i]   <= mp[i-1];
         mrob[i] <= mrob[i-1];
      end
   end

   assign mul_exit   = mv[NS-1];
   assign div_signed = (in_opcode == OP_DIV) | (in_opcode == OP_REM);

   serial_divider #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_acc),
      .abort     (flush),
      .stall     (mul_exit),
      .is_signed (div_signed),
      .dividend  (in_src1_val),
      .divisor   (in_src2_val),
      .done      (div_done),
      .idle      (div_idle),
      .quotient  (div_q),
      .remainder (div_r)
   );

   always_ff @(posedge clk) begin
      if (div_acc) begin
         d_rem  <= (in_opcode == OP_REM) | (in_opcode == OP_REMU);
         d_preg <= in_dst_preg;
         d_rob  <= in_rob_idx;
      end
   end

   // Special-case results leave straight from IDLE, before the tags are latched.
   assign sel_rem  = div_idle ? ((in_opcode == OP_REM) | (in_opcode == OP_REMU)) : d_rem;
   assign sel_preg = div_idle ? in_dst_preg : d_preg;
   assign sel_rob  = div_idle ? in_rob_idx : d_rob;
   assign div_val  = sel_rem ? div_r : div_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid    <= 1'b0;
         wb_val      <= '0;
         wb_dst_preg <= '0;
         wb_rob_idx  <= '0;
      end else begin
         wb_valid <= 1'b0;
         if (!flush) begin
            if (mul_exit) begin
               wb_valid    <= 1'b1;
               wb_val      <= mr[NS-1];
               wb_dst_preg <= mp[NS-1];
               wb_rob_idx  <= mrob[NS-1];
            end else if (div_done) begin
               wb_valid    <= 1'b1;
               wb_val      <= div_val;
               wb_dst_preg <= sel_preg;
               wb_rob_idx  <= sel_rob;
            end
         end
      end
   end

   assign busy = (|mv) | ~div_idle;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: one instance at MUL_STAGES=3 and one at
// MUL_STAGES=2 share the same stimulus.
module tb_execute_muldiv;
   import execute_muldiv_pkg::*;

   logic          clk = 1'b0;
   logic          rst, in_valid, flush;
   instr_opcode_t in_opcode;
   logic [31:0]   in_src1_val, in_src2_val;
   logic [5:0]    in_dst_preg, in_rob_idx;

   logic          in_ready, wb_valid, busy;
   logic [31:0]   wb_val;
   logic [5:0]    wb_dst_preg, wb_rob_idx;

   logic          in_ready2, wb_valid2, busy2;
   logic [31:0]   wb_val2;
   logic [5:0]    wb_dst_preg2, wb_rob_idx2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   execute_muldiv #(.XLEN(32), .MUL_STAGES(3), .ROB_ENTRIES(64), .NUM_PREGS(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_src1_val(in_src1_val), .in_src2_val(in_src2_val),
      .in_dst_preg(in_dst_preg), .in_rob_idx(in_rob_idx), .flush(flush),
      .wb_valid(wb_valid), .wb_val(wb_val), .wb_dst_preg(wb_dst_preg),
      .wb_rob_idx(wb_rob_idx), .busy(busy)
   );

   execute_muldiv #(.XLEN(32), .MUL_STAGES(2), .ROB_ENTRIES(64), .NUM_PREGS(64)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_opcode(in_opcode), .in_src1_val(in_src1_val), .in_src2_val(in_src2_val),
      .in_dst_preg(in_dst_preg), .in_rob_idx(in_rob_idx), .flush(flush),
      .wb_valid(wb_valid2), .wb_val(wb_val2), .wb_dst_preg(wb_dst_preg2),
      .wb_rob_idx(wb_rob_idx2), .busy(busy2)
   );

   task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input instr_opcode_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] preg, input logic [5:0] rob);
      in_valid    = 1'b1;
      in_opcode   = op;
      in_src1_val = a;
      in_src2_val = b;
      in_dst_preg = preg;
      in_rob_idx  = rob;
      tick(1);
      in_valid    = 1'b0;
   endtask

   task automatic mul_case(input string tag, input instr_opcode_t op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expv);
      send(op, a, b, 6'd1, 6'd2);
      tick(2);
      chk({tag, "_valid"}, wb_valid, 1);
      chk({tag, "_val"}, wb_val, expv);
      tick(1);
   endtask

   task automatic div_case(input string tag, input instr_opcode_t op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expv);
      logic bad;
      bad = 1'b0;
      send(op, a, b, 6'd7, 6'd9);
      for (int c = 1; c <= 33; c++) begin
         bad = bad | in_ready | wb_valid;
         tick(1);
      end
      chk({tag, "_ready_wb_low"}, bad, 0);
      chk({tag, "_valid34"}, wb_valid, 1);
      chk({tag, "_val"}, wb_val, expv);
      chk({tag, "_rob"}, wb_rob_idx, 9);
      tick(1);
      chk({tag, "_done"}, wb_valid, 0);
   endtask

   task automatic spec_case(input string tag, input instr_opcode_t op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] expv);
      send(op, a, b, 6'd3, 6'd4);
      chk({tag, "_valid1"}, wb_valid, 1);
      chk({tag, "_val"}, wb_val, expv);
      tick(1);
      chk({tag, "_after"}, wb_valid, 0);
   endtask

   initial begin
      logic bad;
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_opcode = OP_ADD;
      in_src1_val = '0; in_src2_val = '0; in_dst_preg = '0; in_rob_idx = '0;
      tick(2);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_val", wb_val, 0);
      chk("rst_wb_preg", wb_dst_preg, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", in_ready, 1);

      send(OP_MUL, 32'd7, 32'd6, 6'd33, 6'd5);
      chk("mul_c1_wb", wb_valid, 0);
      chk("mul_c1_busy", busy, 1);
      tick(1);
      chk("mul_c2_wb", wb_valid, 0);
      tick(1);
      chk("mul_c3_wb", wb_valid, 1);
      chk("mul_c3_val", wb_val, 42);
      chk("mul_c3_preg", wb_dst_preg, 33);
      chk("mul_c3_rob", wb_rob_idx, 5);
      tick(1);
      chk("mul_c4_wb", wb_valid, 0);
      chk("mul_c4_busy", busy, 0);

      mul_case("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      mul_case("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      mul_case("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
      mul_case("mul_neg_lo", OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);

      send(OP_ADD, 32'd1, 32'd1, 6'd1, 6'd1);
      chk("nonmd_busy", busy, 0);
      bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         bad = bad | wb_valid;
         tick(1);
      end
      chk("nonmd_no_wb", bad, 0);

      div_case("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      div_case("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      div_case("divu", OP_DIVU, 32'd100, 32'd7, 32'd14);
      div_case("remu", OP_REMU, 32'd100, 32'd7, 32'd2);

      spec_case("div_by0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
      spec_case("rem_by0", OP_REM, 32'd5, 32'd0, 32'd5);
      spec_case("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      spec_case("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

      for (int k = 0; k <= 6; k++) begin
         if (k < 4) begin
            in_valid    = 1'b1;
            in_opcode   = OP_MUL;
            in_src1_val = 32'(k + 1);
            in_src2_val = 32'(k + 1);
            in_rob_idx  = 6'(k + 10);
         end else begin
            in_valid = 1'b0;
         end
         tick(1);
         if (k >= 2 && k <= 5) begin
            chk("b2b_valid", wb_valid, 1);
            chk("b2b_val", wb_val, 64'((k - 1) * (k - 1)));
         end else if (k == 6) begin
            chk("b2b_end", wb_valid, 0);
         end
      end
      tick(2);

      send(OP_MUL, 32'd3, 32'd5, 6'd20, 6'd21);
      in_valid    = 1'b1;
      in_opcode   = OP_DIV;
      in_src1_val = 32'd9;
      in_src2_val = 32'd0;
      in_dst_preg = 6'd22;
      in_rob_idx  = 6'd23;
      tick(1);
      in_valid = 1'b0;
      chk("arb2_mul_first", wb_valid2, 1);
      chk("arb2_mul_val", wb_val2, 15);
      chk("arb3_div_first", wb_val, 32'hFFFF_FFFF);
      tick(1);
      chk("arb2_div_next", wb_valid2, 1);
      chk("arb2_div_val", wb_val2, 32'hFFFF_FFFF);
      chk("arb2_div_rob", wb_rob_idx2, 23);
      chk("arb3_mul_val", wb_val, 15);
      tick(1);
      chk("arb2_idle", busy2, 0);

      send(OP_DIVU, 32'd100, 32'd7, 6'd8, 6'd8);
      tick(9);
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_opcode = OP_MUL;
      tick(1);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_wb", wb_valid, 0);
      chk("flush_busy", busy, 0);
      chk("flush_ready", in_ready, 1);
      bad = 1'b0;
      for (int c = 0; c < 30; c++) begin
         bad = bad | wb_valid;
         tick(1);
      end
      chk("flush_no_wb", bad, 0);

      flush = 1'b1;
      send(OP_MUL, 32'd2, 32'd2, 6'd1, 6'd1);
      flush = 1'b0;
      chk("flush_noaccept_busy", busy, 0);
      tick(3);
      chk("flush_noaccept_wb", wb_valid, 0);

      mul_case("post_flush", OP_MUL, 32'd3, 32'd3, 32'd9);

      send(OP_MUL, 32'd4, 32'd4, 6'd5, 6'd6);
      tick(2);
      chk("pre_rst_wb", wb_valid, 1);
      rst = 1'b1;
      tick(1);
      chk("midrst_wb_valid", wb_valid, 0);
      chk("midrst_wb_val", wb_val, 0);
      chk("midrst_ready", in_ready, 0);
      rst = 1'b0;
      tick(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
